seven_segment_scan: RTL and testbench
=====================================

Name: seven_segment_scan

Overview:
- Parametrised successor to the single-digit hex-to-seven-segment decoder.
- Drives a time-multiplexed bank of DIGITS common-anode/cathode displays from one packed hex value, one digit at a time.
- Adds a refresh prescaler, double-buffered value loading (no tearing mid-frame), leading-zero blanking, per-digit decimal points and selectable output polarity.
- Sits between the datapath producing a display value and the board display pins.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 1000, clock cycles each digit stays lit; legal minimum 1.
- SEG_ACTIVE_LOW, 0, 1 inverts segment and dp outputs.
- AN_ACTIVE_LOW, 0, 1 inverts anode outputs.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  capture value and dp_in into the shadow register this cycle.
- value  input  4*DIGITS  packed hex digits; digit k is value[4k+3:4k], and digit 0 is least significant.
- dp_in  input  DIGITS  decimal point request per digit.
- blank_lz  input  1  enables leading-zero blanking; sampled continuously.
- Segment  output  7  segments ABCDEFG, with A at bit 6 and G at bit 0.
- dp  output  1  decimal point of the active digit.
- anode  output  DIGITS  one-hot digit enable.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- State:
  - prescaler pc, range 0..REFRESH_DIV-1.
  - digit index idx, range 0..DIGITS-1.
  - shadow registers sh_val and sh_dp.
  - display registers disp_val and disp_dp.
  - registered outputs.
- Reset (rst=1 at an edge):
  - pc, idx, sh_*, disp_* are cleared to 0.
  - Segment, dp and anode go to the inactive level: all 0 when active-high, all 1 when the corresponding ACTIVE_LOW parameter is set.
  - frame_tick goes to 0.
  - A load asserted in the same cycle is discarded.
  - Reset mid-frame aborts the scan; scanning restarts at digit 0.
- Prescaler:
  - tick = (pc == REFRESH_DIV-1).
  - On tick: pc <= 0 and idx <= (idx == DIGITS-1) ? 0 : idx+1.
  - Otherwise pc <= pc+1.
  - With REFRESH_DIV = 1, tick is asserted every cycle.
- Shadow: sh_val/sh_dp <= value/dp_in whenever load=1 (and rst=0).
- Frame boundary = tick AND idx == DIGITS-1:
  - disp_val/disp_dp <= load ? value/dp_in : sh_val/sh_dp.
  - A load coincident with the boundary is therefore displayed in the next frame.
  - disp_* never changes at any other time.
- Output register (one-cycle latency from idx, disp_*):
  - anode = one-hot of idx.
  - Segment = decode of disp_val digit idx.
  - dp = disp_dp[idx].
  - frame_tick = (idx == 0 AND pc == 0).
  - Consequence: frame_tick is high exactly in the first cycle anode shows digit 0, including the first frame after reset.
- Decode, active-high ABCDEFG:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Leading-zero blanking:
  - When blank_lz=1, digit k>0 is blanked if disp_val digits DIGITS-1..k are all zero.
  - A blanked digit drives Segment inactive, but its anode still scans and its dp still follows disp_dp.
  - Digit 0 is never blanked.
- Polarity: inversion is applied last, after blanking.
- DIGITS=1: idx is constant 0, and every tick is a frame boundary.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=4, active-high unless stated.
- Reset sequence: rst high for 3 cycles, then low -> during reset Segment=0000000, anode=0000, dp=0, frame_tick=0. In the first cycle after release: anode=0001, Segment=1111110, frame_tick=1. Anode steps 0010, 0100, 1000 every 4 cycles, and frame_tick repeats every 16 cycles.
- Decode sweep: load value=16'h3210, then 16'h7654, 16'hBA98, 16'hFEDC, one per frame -> each digit's Segment matches the table for all 16 codes. Each new value first appears in the frame following its load.
- Tearing guard: load 16'h1234 while anode=0100 mid-frame -> remaining digits of the current frame still show the old value; 1234 appears from the next frame_tick. Load asserted exactly on the boundary cycle takes effect in the next frame.
- Blanking: value=16'h0050, blank_lz=1 -> digits 3 and 2 show 0000000, digit 1 shows 1011011, digit 0 shows 1111110. Value=16'h0000 -> only digit 0 is lit. With blank_lz=0, all four digits are lit.
- dp and polarity: SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, value=16'h0008, dp_in=4'b0100 -> when digit 0 is active, anode=1110 and Segment=0000000. When digit 2 is active, dp=0.
- Reset mid-operation plus edge parameters: assert rst while anode=1000 with a pending load -> outputs go inactive, and after release scanning restarts at digit 0 showing 0 (the pending load is lost). With DIGITS=1, REFRESH_DIV=1, frame_tick=1 every cycle and a load shows on the next cycle.

Source files
------------

// File: rtl/seven_segment_scan.sv
// Time-multiplexed hex display driver: refresh prescaler, frame-synchronous
// double-buffered value, leading-zero blanking and selectable polarity.
module seven_segment_scan #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            Segment,
    output logic                  dp,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_tick
);

    localparam int PCW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PCW-1:0]    PC_LAST  = PCW'(REFRESH_DIV - 1);
    localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

    logic [PCW-1:0]      pc_q, pc_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_val_q, sh_val_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   anode_q, anode_d;
    logic                ft_q, ft_d;

    logic                tick;
    logic                frame_end;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_lz;
    logic                zero_run;
    logic [DIGITS-1:0]   lead_zero;
    logic [DIGITS-1:0]   one_hot;
    logic [6:0]          seg_raw;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'b0000000;
        unique case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign tick      = (pc_q == PC_LAST);
    assign frame_end = tick && (idx_q == IDX_LAST);

    always_comb begin
        pc_d  = pc_q + PCW'(1);
        idx_d = idx_q;
        if (tick) begin
            pc_d  = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
        end
    end

    // Display copy only moves at the frame boundary so a frame never tears.
    always_comb begin
        sh_val_d   = load ? value : sh_val_q;
        sh_dp_d    = load ? dp_in : sh_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (frame_end) begin
            disp_val_d = load ? value : sh_val_q;
            disp_dp_d  = load ? dp_in : sh_dp_q;
        end
    end

    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & (disp_val_q[4*k +: 4] == 4'h0);
            lead_zero[k] = zero_run;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        one_hot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDXW'(k)) begin
                cur_nib    = disp_val_q[4*k +: 4];
                cur_dp     = disp_dp_q[k];
                cur_lz     = lead_zero[k] && (k != 0);
                one_hot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_raw = (blank_lz && cur_lz) ? 7'b0000000 : hex2seg(cur_nib);
        seg_d   = seg_raw ^ SEG_OFF;
        dp_d    = cur_dp ^ DP_OFF;
        anode_d = one_hot ^ AN_OFF;
        ft_d    = (idx_q == '0) && (pc_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            idx_q      <= '0;
            sh_val_q   <= '0;
            sh_dp_q    <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
            anode_q    <= AN_OFF;
            ft_q       <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            idx_q      <= idx_d;
            sh_val_q   <= sh_val_d;
            sh_dp_q    <= sh_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            anode_q    <= anode_d;
            ft_q       <= ft_d;
        end
    end

    assign Segment    = seg_q;
    assign dp         = dp_q;
    assign anode      = anode_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: cycle-count reference model checked every
// cycle on three configurations, plus directed literal expectations.
module tb_seven_segment_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;

    logic [6:0] segA, segB, segC;
    logic       dpA, dpB, dpC;
    logic [3:0] anA, anB;
    logic [0:0] anC;
    logic       ftA, ftB, ftC;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    seven_segment_scan #(.DIGITS(4), .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dutA (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .Segment(segA), .dp(dpA), .anode(anA),
        .frame_tick(ftA));

    seven_segment_scan #(.DIGITS(4), .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dutB (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .Segment(segB), .dp(dpB), .anode(anB),
        .frame_tick(ftB));

    seven_segment_scan #(.DIGITS(1), .REFRESH_DIV(1),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dutC (
        .clk(clk), .rst(rst), .load(load), .value(value[3:0]),
        .dp_in(dp_in[0:0]), .blank_lz(blank_lz), .Segment(segC), .dp(dpC),
        .anode(anC), .frame_tick(ftC));

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    typedef struct packed {
        int         D;
        int         RD;
        bit         sal;
        bit         aal;
        int         n;
        logic [31:0] sh;
        logic [31:0] disp;
        logic [7:0]  shdp;
        logic [7:0]  dispdp;
        logic [6:0]  seg;
        logic        dp;
        logic [7:0]  an;
        logic        ft;
    } mdl_t;

    mdl_t mA, mB, mC;

    // Position in the scan is derived purely from cycles since reset.
    function automatic mdl_t step(mdl_t m, logic r, logic ld,
                                  logic [31:0] v, logic [7:0] dpi,
                                  logic blz);
        int pos;
        int dig;
        logic [31:0] vmask;
        logic [7:0] dmask;
        logic [3:0] nib;
        bit blanked;
        vmask = (m.D == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * m.D)) - 32'd1);
        dmask = 8'((9'd1 << m.D) - 9'd1);
        if (r) begin
            m.n = 0;
            m.sh = '0;
            m.disp = '0;
            m.shdp = '0;
            m.dispdp = '0;
            m.seg = m.sal ? 7'h7F : 7'h00;
            m.dp = m.sal;
            m.an = m.aal ? dmask : 8'h00;
            m.ft = 1'b0;
            return m;
        end
        pos = m.n % (m.D * m.RD);
        dig = pos / m.RD;
        nib = 4'(m.disp >> (4 * dig));
        blanked = blz && (dig > 0) && ((m.disp >> (4 * dig)) == 32'd0);
        m.seg = blanked ? 7'h00 : SEG_TAB[nib];
        if (m.sal) m.seg = ~m.seg;
        m.dp = m.dispdp[dig] ^ m.sal;
        m.an = 8'(32'd1 << dig);
        if (m.aal) m.an = ~m.an & dmask;
        m.ft = (pos == 0);
        if (pos == m.D * m.RD - 1) begin
            m.disp = (ld ? v : m.sh) & vmask;
            m.dispdp = (ld ? dpi : m.shdp) & dmask;
        end
        if (ld) begin
            m.sh = v & vmask;
            m.shdp = dpi & dmask;
        end
        m.n = m.n + 1;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    initial begin
        mA = '0; mA.D = 4; mA.RD = 4; mA.sal = 1'b0; mA.aal = 1'b0;
        mB = '0; mB.D = 4; mB.RD = 4; mB.sal = 1'b1; mB.aal = 1'b1;
        mC = '0; mC.D = 1; mC.RD = 1; mC.sal = 1'b0; mC.aal = 1'b0;
    end

    always @(posedge clk) begin
        mA <= step(mA, rst, load, {16'h0, value}, {4'h0, dp_in}, blank_lz);
        mB <= step(mB, rst, load, {16'h0, value}, {4'h0, dp_in}, blank_lz);
        mC <= step(mC, rst, load, {28'h0, value[3:0]}, {7'h0, dp_in[0]},
                   blank_lz);
        started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("mdl_segA", 32'(segA), 32'(mA.seg));
            chk("mdl_dpA", 32'(dpA), 32'(mA.dp));
            chk("mdl_anA", 32'(anA), 32'(mA.an[3:0]));
            chk("mdl_ftA", 32'(ftA), 32'(mA.ft));
            chk("mdl_segB", 32'(segB), 32'(mB.seg));
            chk("mdl_dpB", 32'(dpB), 32'(mB.dp));
            chk("mdl_anB", 32'(anB), 32'(mB.an[3:0]));
            chk("mdl_ftB", 32'(ftB), 32'(mB.ft));
            chk("mdl_segC", 32'(segC), 32'(mC.seg));
            chk("mdl_dpC", 32'(dpC), 32'(mC.dp));
            chk("mdl_anC", 32'(anC), 32'(mC.an[0:0]));
            chk("mdl_ftC", 32'(ftC), 32'(mC.ft));
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (anA !== pat && t < 40);
        chk("wait_an", 32'(anA), 32'(pat));
    endtask

    task automatic wait_ft();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ftA !== 1'b1 && t < 40);
        chk("wait_ft", 32'(ftA), 32'(1'b1));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    // Called at the first cycle of a frame; leaves off in digit 3.
    task automatic chk_frame(input string nm, input logic [6:0] e0,
                             input logic [6:0] e1, input logic [6:0] e2,
                             input logic [6:0] e3);
        chk({nm, "_d0"}, 32'(segA), 32'(e0));
        cyc(4);
        chk({nm, "_d1"}, 32'(segA), 32'(e1));
        cyc(4);
        chk({nm, "_d2"}, 32'(segA), 32'(e2));
        cyc(4);
        chk({nm, "_d3"}, 32'(segA), 32'(e3));
    endtask

    initial begin
        cyc(1);
        chk("rst_segA", 32'(segA), 32'(7'b0000000));
        chk("rst_anA", 32'(anA), 32'(4'b0000));
        chk("rst_dpA", 32'(dpA), 32'(1'b0));
        chk("rst_ftA", 32'(ftA), 32'(1'b0));
        chk("rst_segB", 32'(segB), 32'(7'b1111111));
        chk("rst_anB", 32'(anB), 32'(4'b1111));
        chk("rst_dpB", 32'(dpB), 32'(1'b1));
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("rel_anA", 32'(anA), 32'(4'b0001));
        chk("rel_segA", 32'(segA), 32'(7'b1111110));
        chk("rel_ftA", 32'(ftA), 32'(1'b1));
        chk("rel_anB", 32'(anB), 32'(4'b1110));
        chk("rel_segB", 32'(segB), 32'(7'b0000001));
        chk("rel_ftC", 32'(ftC), 32'(1'b1));
        chk("rel_segC", 32'(segC), 32'(7'b1111110));
        cyc(4);
        chk("step_an1", 32'(anA), 32'(4'b0010));
        chk("step_ft1", 32'(ftA), 32'(1'b0));
        cyc(4);
        chk("step_an2", 32'(anA), 32'(4'b0100));
        cyc(4);
        chk("step_an3", 32'(anA), 32'(4'b1000));
        cyc(4);
        chk("period_an", 32'(anA), 32'(4'b0001));
        chk("period_ft", 32'(ftA), 32'(1'b1));

        do_load(16'h3210, 4'h0);
        wait_ft();
        chk_frame("dec0", 7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001);
        do_load(16'h7654, 4'h0);
        wait_ft();
        chk_frame("dec1", 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000);
        do_load(16'hBA98, 4'h0);
        wait_ft();
        chk_frame("dec2", 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111);
        do_load(16'hFEDC, 4'h0);
        wait_ft();
        chk_frame("dec3", 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111);

        wait_ft();
        wait_an(4'b0100);
        do_load(16'h1234, 4'h0);
        wait_an(4'b1000);
        chk("tear_old", 32'(segA), 32'(7'b1000111));
        wait_ft();
        chk_frame("tear_new", 7'b0110011, 7'b1111001, 7'b1101101,
                  7'b0110000);
        cyc(2);
        do_load(16'hABCD, 4'h0);
        wait_ft();
        chk_frame("bound", 7'b0111101, 7'b1001110, 7'b0011111, 7'b1110111);

        blank_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        wait_ft();
        chk_frame("blank50", 7'b1111110, 7'b1011011, 7'b0000000,
                  7'b0000000);
        do_load(16'h0000, 4'h0);
        wait_ft();
        chk_frame("blank0", 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000);
        blank_lz = 1'b0;
        wait_ft();
        chk_frame("noblank", 7'b1111110, 7'b1111110, 7'b1111110,
                  7'b1111110);

        do_load(16'h0008, 4'b0100);
        wait_ft();
        chk("pol_anB0", 32'(anB), 32'(4'b1110));
        chk("pol_segB0", 32'(segB), 32'(7'b0000000));
        chk("pol_dpB0", 32'(dpB), 32'(1'b1));
        cyc(8);
        chk("pol_anB2", 32'(anB), 32'(4'b1011));
        chk("pol_dpB2", 32'(dpB), 32'(1'b0));
        chk("pol_dpA2", 32'(dpA), 32'(1'b1));

        wait_an(4'b1000);
        value = 16'h5555;
        dp_in = 4'hF;
        load = 1'b1;
        rst = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("mid_rst_segA", 32'(segA), 32'(7'b0000000));
        chk("mid_rst_anA", 32'(anA), 32'(4'b0000));
        chk("mid_rst_anB", 32'(anB), 32'(4'b1111));
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("restart_an", 32'(anA), 32'(4'b0001));
        chk("restart_ft", 32'(ftA), 32'(1'b1));
        chk_frame("restart", 7'b1111110, 7'b1111110, 7'b1111110,
                  7'b1111110);
        wait_ft();
        chk("lost_load", 32'(segA), 32'(7'b1111110));
        chk("lost_dp", 32'(dpA), 32'(1'b0));

        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("c_ft", 32'(ftC), 32'(1'b1));
        end
        value = 16'h0007;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("c_old", 32'(segC), 32'(7'b1111110));
        cyc(1);
        chk("c_new", 32'(segC), 32'(7'b1110000));
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
